// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the MEM-stage data responder.
// Access-width codes, MMIO offsets and width helpers.
package dmem_responder_pkg;

  localparam logic [2:0] DM_LW  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LHU = 3'b010;
  localparam logic [2:0] DM_LB  = 3'b011;
  localparam logic [2:0] DM_LBU = 3'b100;

  localparam logic [4:0] MMIO_LED     = 5'h00;
  localparam logic [4:0] MMIO_SW      = 5'h04;
  localparam logic [4:0] MMIO_CYCLE   = 5'h08;
  localparam logic [4:0] MMIO_ERR     = 5'h0C;
  localparam logic [4:0] MMIO_ERRADDR = 5'h10;

  typedef enum logic [1:0] {
    ACC_WORD,
    ACC_HALF,
    ACC_BYTE
  } acc_w_e;

  function automatic acc_w_e acc_width(
    input logic [2:0] ctrl
  );
    acc_w_e w;
    w = ACC_WORD;
    if (ctrl == DM_LH || ctrl == DM_LHU)
      w = ACC_HALF;
    if (ctrl == DM_LB || ctrl == DM_LBU)
      w = ACC_BYTE;
    return w;
  endfunction

  function automatic logic acc_signed(
    input logic [2:0] ctrl
  );
    return ctrl == DM_LH || ctrl == DM_LB;
  endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for stores and extension for loads.
// Purely combinational; flags width-misaligned accesses.
module dm_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        misaligned
);

  acc_w_e      w;
  logic        sext;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  assign w      = acc_width(dm_ctrl);
  assign sext   = acc_signed(dm_ctrl);
  assign half_v = lane[1] ? rword[31:16]
                          : rword[15:0];
  assign byte_v = rword[{lane, 3'b000} +: 8];

  always_comb begin
    byte_en    = 4'b1111;
    st_word    = wdata;
    ld_word    = rword;
    misaligned = 1'b0;
    unique case (w)
      ACC_HALF: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100
                             : 4'b0011;
        st_word    = {2{wdata[15:0]}};
        ld_word    = {{16{sext & half_v[15]}},
                      half_v};
      end
      ACC_BYTE: begin
        byte_en = 4'b0001 << lane;
        st_word = {4{wdata[7:0]}};
        ld_word = {{24{sext & byte_v[7]}},
                   byte_v};
      end
      default: begin
        misaligned = |lane;
      end
    endcase
    // a faulting access must neither write nor leak data
    if (misaligned) begin
      byte_en = 4'b0000;
      ld_word = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: word RAM with byte lanes
// plus an MMIO window (LED, switches, cycle, error).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        err_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ram_word;
  logic [3:0]        byte_en;
  logic [31:0]       st_word;
  logic [31:0]       ld_word;
  logic              misaligned;
  logic              is_mmio;
  logic              st_ok;
  logic [4:0]        off;
  logic              unused;

  logic [15:0] led;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] cycle;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] mmio_rd;

  logic sel_led, sel_sw, sel_cyc;
  logic sel_err, sel_ea;

  assign idx      = addr[ADDR_W+1:2];
  assign ram_word = ram[idx];
  assign is_mmio  = addr[31:16] == MMIO_BASE[31:16];
  assign off      = addr[4:0];
  assign st_ok    = reset & mem_w & ~misaligned;
  assign unused   = ^addr;

  assign sel_led = off == MMIO_LED;
  assign sel_sw  = off == MMIO_SW;
  assign sel_cyc = off == MMIO_CYCLE;
  assign sel_err = off == MMIO_ERR;
  assign sel_ea  = off == MMIO_ERRADDR;

  dm_lane_align u_align (
    .lane       (addr[1:0]),
    .dm_ctrl    (dm_ctrl),
    .wdata      (wdata),
    .rword      (ram_word),
    .byte_en    (byte_en),
    .st_word    (st_word),
    .ld_word    (ld_word),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (st_ok && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          ram[idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led      <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      cycle    <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      cycle   <= cycle + 32'd1;
      if (st_ok && is_mmio && sel_led)
        led <= wdata[15:0];
      // first fault wins; clear only via aligned write
      if (misaligned) begin
        err <= 1'b1;
        if (!err)
          err_addr <= addr;
      end else if (st_ok && is_mmio && sel_err) begin
        err      <= 1'b0;
        err_addr <= '0;
      end
    end
  end

  always_comb begin
    mmio_rd = '0;
    unique case (1'b1)
      sel_led: mmio_rd = {16'b0, led};
      sel_sw:  mmio_rd = {16'b0, sw_sync};
      sel_cyc: mmio_rd = cycle;
      sel_err: mmio_rd = {31'b0, err};
      sel_ea:  mmio_rd = err_addr;
      default: mmio_rd = '0;
    endcase
  end

  assign rdata   = misaligned ? 32'b0
                 : is_mmio    ? mmio_rd
                              : ld_word;
  assign led_out = led;
  assign err_out = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Expected load data queued at drive, popped at sample.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] M_LED = 32'hFFFF_0000;
  localparam logic [31:0] M_SW  = 32'hFFFF_0004;
  localparam logic [31:0] M_CYC = 32'hFFFF_0008;
  localparam logic [31:0] M_ERR = 32'hFFFF_000C;
  localparam logic [31:0] M_EA  = 32'hFFFF_0010;

  logic        clk;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        err_out;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;

  dmem_responder dut (
    .clk     (clk),
    .reset   (reset),
    .mem_w   (mem_w),
    .addr    (addr),
    .wdata   (wdata),
    .dm_ctrl (dm_ctrl),
    .rdata   (rdata),
    .sw_in   (sw_in),
    .led_out (led_out),
    .err_out (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic access(
    input logic        we,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  c,
    input bit          chk,
    input logic [31:0] exp,
    input string       tag
  );
    exp_t e;
    mem_w   = we;
    addr    = a;
    wdata   = d;
    dm_ctrl = c;
    if (chk) begin
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
    end
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(e.tag, rdata, e.exp);
    end
    @(negedge clk);
    mem_w   = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    dm_ctrl = DM_LW;
  endtask

  task automatic st(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [2:0]  c
  );
    access(1'b1, a, d, c, 1'b0, 32'h0, "");
  endtask

  task automatic ld(
    input logic [31:0] a,
    input logic [2:0]  c,
    input logic [31:0] exp,
    input string       tag
  );
    access(1'b0, a, 32'h0, c, 1'b1, exp, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b0;
    mem_w   = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;
    dm_ctrl = DM_LW;
    sw_in   = 16'h0;
    #1;
    check("rst_led", {16'b0, led_out}, 32'h0);
    check("rst_err", {31'b0, err_out}, 32'h0);
    ld(M_CYC, DM_LW, 32'h0, "rst_cycle");
    reset = 1'b1;

    repeat (5) access(1'b0, 32'h0, 32'h0,
                      DM_LW, 1'b0, 32'h0, "");
    ld(M_CYC, DM_LW, 32'd5, "cycle_e5");
    ld(M_CYC, DM_LW, 32'd6, "cycle_e6");

    st(32'h100, 32'h1234_5678, DM_LW);
    ld(32'h100, DM_LW, 32'h1234_5678, "sw_lw");
    st(32'h101, 32'h0000_00AB, DM_LB);
    ld(32'h100, DM_LW, 32'h1234_AB78, "sb_lw");

    st(32'h0008_0100, 32'hCAFE_BABE, DM_LW);
    ld(32'h100, DM_LW, 32'hCAFE_BABE, "alias");
    access(1'b1, 32'h100, 32'h1111_2222, DM_LW,
           1'b1, 32'hCAFE_BABE, "rd_old");
    ld(32'h100, DM_LW, 32'h1111_2222, "rd_new");

    st(32'h20, 32'h80FF_7F01, DM_LW);
    ld(32'h23, DM_LB,  32'hFFFF_FF80, "lb");
    ld(32'h23, DM_LBU, 32'h0000_0080, "lbu");
    ld(32'h22, DM_LH,  32'hFFFF_80FF, "lh");
    ld(32'h20, DM_LHU, 32'h0000_7F01, "lhu");
    st(32'h22, 32'h1234_BEEF, DM_LH);
    ld(32'h20, DM_LW,  32'hBEEF_7F01, "sh_lw");

    access(1'b1, 32'h102, 32'h0000_DEAD, DM_LW,
           1'b1, 32'h0, "mis_rd");
    check("err_set", {31'b0, err_out}, 32'h1);
    ld(32'h100, DM_LW, 32'h1111_2222, "mis_nowr");
    ld(32'h105, DM_LW, 32'h0, "mis2_rd");
    ld(M_EA,  DM_LW, 32'h102, "errad_1st");
    ld(M_ERR, DM_LW, 32'h1, "err_rd");
    st(32'hFFFF_000E, 32'h0, DM_LW);
    check("err_noclr", {31'b0, err_out}, 32'h1);
    st(M_ERR, 32'h0, DM_LW);
    check("err_clr", {31'b0, err_out}, 32'h0);
    ld(M_EA, DM_LW, 32'h0, "errad_clr");

    st(M_LED, 32'h0000_00FF, DM_LW);
    check("led_out", {16'b0, led_out}, 32'hFF);
    ld(M_LED, DM_LW, 32'hFF, "led_rd");
    st(32'hFFFF_0014, 32'h1, DM_LW);
    ld(32'hFFFF_0014, DM_LW, 32'h0, "unmapped");

    sw_in = 16'hA5A5;
    ld(M_SW, DM_LW, 32'h0,    "sw_t0");
    ld(M_SW, DM_LW, 32'h0,    "sw_t1");
    ld(M_SW, DM_LW, 32'hA5A5, "sw_t2");

    force dut.cycle = 32'hFFFF_FFFF;
    addr = M_CYC;
    #2;
    check("cyc_max", rdata, 32'hFFFF_FFFF);
    release dut.cycle;
    @(negedge clk);
    ld(M_CYC, DM_LW, 32'h0, "cyc_wrap");

    reset = 1'b0;
    #1;
    check("mid_led", {16'b0, led_out}, 32'h0);
    ld(M_CYC, DM_LW, 32'h0, "mid_cyc");
    ld(M_LED, DM_LW, 32'h0, "mid_ledrd");
    st(32'h100, 32'hBAD0_BAD0, DM_LW);
    reset = 1'b1;
    ld(32'h100, DM_LW, 32'h1111_2222, "rst_nowr");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
